ex_div_unit: RTL and testbench
==============================

Name: ex_div_unit

Overview:
- Iterative radix-2 restoring divider in the EX stage for MIPS DIV/DIVU.
- It is the requester side of the EX stall interface. Its `stall_req` drives the pipeline controller's EX stall request, which freezes the IF/ID/EX stages.
- It consumes the controller's EX-stage flush bit and EX-advance indication.
- Results go to the HI/LO writeback path.

Parameters:
- DATA_W, 32, operand and result width.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > DATA_W.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- start  input  1  the EX-stage instruction is DIV/DIVU with valid operands.
- signed_op  input  1  1 = DIV (two's complement), 0 = DIVU.
- dividend  input  DATA_W  rs operand.
- divisor  input  DATA_W  rt operand.
- flush  input  1  EX flush bit from the pipeline controller; aborts the operation.
- ex_advance  input  1  EX stage advances this cycle (EX stall bit is low).
- stall_req  output  1  EX stall request to the pipeline controller (combinational).
- done  output  1  hi/lo valid for the EX instruction this cycle (registered state decode).
- lo  output  DATA_W  quotient (registered).
- hi  output  DATA_W  remainder (registered).

Behaviour:
Reset:
- rst=1 at a rising edge forces: state=IDLE, counter=0, internal registers=0, lo=0, hi=0.
- While rst=1, stall_req=0 and done=0.
- Reset mid-operation discards all progress.

States: IDLE, BUSY, DONE.
- IDLE, start=1, flush=0, divisor!=0:
  - latch |dividend| and |divisor| (magnitudes only when signed_op=1);
  - latch the sign flags: quotient negative = sign(dividend) XOR sign(divisor); remainder negative = sign(dividend);
  - clear the partial remainder and counter; go to BUSY.
- IDLE, start=1, flush=0, divisor==0:
  - lo <= all ones, hi <= dividend (signedness ignored); go to DONE.
- BUSY, one quotient bit per cycle, MSB first:
  - shift {rem, quo} left by 1;
  - trial = rem - divisor_mag at DATA_W+1 bits;
  - if trial is non-negative, rem <= trial and the quotient LSB = 1.
  - After DATA_W iterations (counter == DATA_W-1), apply the sign fixes (two's-complement negate, wrapping at DATA_W), write lo/hi, and go to DONE.
- DONE: done=1; lo/hi held.
  - ex_advance=1 -> IDLE.
  - Otherwise stay in DONE (downstream stall) with stall_req=0.
- lo/hi hold their last values in IDLE; done=0 outside DONE.

stall_req:
- stall_req = !rst & !flush & ((IDLE & start) | BUSY).
- It is never asserted in DONE, so the instruction can leave EX.

Latency:
- Start seen in IDLE at cycle 0; BUSY for cycles 1..DATA_W; DONE at cycle DATA_W+1.
- stall_req is high for exactly DATA_W+1 consecutive cycles (33 at the default).
- Divide by zero: stall_req is high for 1 cycle; DONE at cycle 1.

Flush:
- flush=1 in any state: stall_req=0 that same cycle, state <= IDLE, lo/hi not updated, done not asserted afterwards.
- flush=1 in the same cycle as an IDLE start means the operation never begins.

Overflow and boundaries:
- Signed 0x80000000 / -1 gives lo=0x80000000, hi=0 via wrap; no trap.

Back-to-back:
- DONE with ex_advance=1 -> IDLE.
- If start is high the next cycle (the next DIV is in EX), the new operation begins with no extra bubble.

Test Plan:
- Unsigned 100 / 7 (signed_op=0, start held) -> stall_req high 33 cycles, then done=1 with lo=14 (0x0000000E), hi=2.
- Signed -7 / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. Signed 7 / -2 -> lo=0xFFFFFFFD, hi=1.
- 5 / 0 -> stall_req high 1 cycle, next cycle done=1, lo=0xFFFFFFFF, hi=5.
- Flush: 100 / 7, assert flush at BUSY cycle 10 -> stall_req=0 that cycle, state IDLE next cycle, done never pulses, lo/hi unchanged from the prior result.
- Back-to-back: signed 0x80000000 / 0xFFFFFFFF, then immediately unsigned 0xFFFFFFFF / 0x10.
  - First result: lo=0x80000000, hi=0.
  - One cycle later the second operation starts; result lo=0x0FFFFFFF, hi=0xF.
  - Also cover DONE held 3 cycles with ex_advance=0: done stays 1, stall_req stays 0.
- Reset: assert rst at BUSY cycle 20 -> next cycle state IDLE, lo=hi=0, stall_req=0, done=0; a fresh 9 / 3 afterwards gives lo=3, hi=0.

Source files
------------

// File: rtl/ex_div_unit_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : ex_div_unit_if
//  Purpose  : EX-stage divider bus. Carries the issue side (operands, start,
//             flush, advance) and the result side (stall request, done, HI/LO).
//  Revision : 1.0 - initial release
// ============================================================================
interface ex_div_unit_if #(
    parameter int DATA_W = 32
);
    logic              start;
    logic              signed_op;
    logic [DATA_W-1:0] dividend;
    logic [DATA_W-1:0] divisor;
    logic              flush;
    logic              ex_advance;
    logic              stall_req;
    logic              done;
    logic [DATA_W-1:0] lo;
    logic [DATA_W-1:0] hi;

    // Pipeline / controller side: issues DIV and DIVU, consumes results.
    modport master (
        output start, signed_op, dividend, divisor, flush, ex_advance,
        input  stall_req, done, lo, hi
    );

    // Divider side.
    modport slave (
        input  start, signed_op, dividend, divisor, flush, ex_advance,
        output stall_req, done, lo, hi
    );
endinterface
`default_nettype wire

// File: rtl/ex_div_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : ex_div_unit
//  Purpose  : Iterative radix-2 restoring divider for MIPS DIV/DIVU in EX.
//             Works on operand magnitudes, one quotient bit per cycle, MSB
//             first, then applies the sign fixes. Holds the pipeline through
//             its stall request until the result is ready.
//  Revision : 1.0 - initial release
// ============================================================================
module ex_div_unit #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 6
) (
    input  wire logic    clk,
    input  wire logic    rst,
    ex_div_unit_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Counter value on the final (DATA_W-th) iteration.
    localparam logic [CNT_W-1:0] c_last_cnt = CNT_W'(DATA_W - 1);

    state_t            r_state;
    state_t            w_next;

    logic [DATA_W-1:0] r_rem;       // partial remainder
    logic [DATA_W-1:0] r_quo;       // dividend bits shifting out, quotient bits in
    logic [DATA_W-1:0] r_dvsr;      // divisor magnitude
    logic [CNT_W-1:0]  r_cnt;
    logic              r_q_neg;
    logic              r_r_neg;
    logic [DATA_W-1:0] r_lo;
    logic [DATA_W-1:0] r_hi;

    logic              w_load;
    logic              w_div0;
    logic              w_step;
    logic              w_finish;

    logic              w_dvd_neg;
    logic              w_dvs_neg;
    logic [DATA_W-1:0] w_dvd_mag;
    logic [DATA_W-1:0] w_dvs_mag;

    logic [DATA_W:0]   w_shift;
    logic              w_ge;
    logic [DATA_W-1:0] w_diff;
    logic [DATA_W-1:0] w_rem_next;
    logic [DATA_W-1:0] w_quo_next;

    // Operand magnitudes; DIVU treats both operands as non-negative.
    assign w_dvd_neg = bus.signed_op & bus.dividend[DATA_W-1];
    assign w_dvs_neg = bus.signed_op & bus.divisor[DATA_W-1];
    assign w_dvd_mag = w_dvd_neg ? (~bus.dividend + 1'b1) : bus.dividend;
    assign w_dvs_mag = w_dvs_neg ? (~bus.divisor + 1'b1) : bus.divisor;

    // One restoring step. The shifted remainder needs DATA_W+1 bits; when it
    // is at least the divisor the difference is below the divisor, so the
    // DATA_W-bit subtraction is exact.
    assign w_shift    = {r_rem, r_quo[DATA_W-1]};
    assign w_ge       = (w_shift >= {1'b0, r_dvsr});
    assign w_diff     = w_shift[DATA_W-1:0] - r_dvsr;
    assign w_rem_next = w_ge ? w_diff : w_shift[DATA_W-1:0];
    assign w_quo_next = {r_quo[DATA_W-2:0], w_ge};

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode and datapath strobes; flush overrides everything.
    always_comb begin
        w_next   = r_state;
        w_load   = 1'b0;
        w_div0   = 1'b0;
        w_step   = 1'b0;
        w_finish = 1'b0;
        if (bus.flush) begin
            w_next = IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        if (bus.divisor == '0) begin
                            w_div0 = 1'b1;
                            w_next = DONE;
                        end else begin
                            w_load = 1'b1;
                            w_next = BUSY;
                        end
                    end
                end
                BUSY: begin
                    w_step = 1'b1;
                    if (r_cnt == c_last_cnt) begin
                        w_finish = 1'b1;
                        w_next   = DONE;
                    end
                end
                DONE: begin
                    if (bus.ex_advance) begin
                        w_next = IDLE;
                    end
                end
                default: begin
                    w_next = IDLE;
                end
            endcase
        end
    end

    // Datapath: operand latch, iteration, and HI/LO result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rem   <= '0;
            r_quo   <= '0;
            r_dvsr  <= '0;
            r_cnt   <= '0;
            r_q_neg <= 1'b0;
            r_r_neg <= 1'b0;
            r_lo    <= '0;
            r_hi    <= '0;
        end else if (w_load) begin
            r_quo   <= w_dvd_mag;
            r_dvsr  <= w_dvs_mag;
            r_rem   <= '0;
            r_cnt   <= '0;
            r_q_neg <= w_dvd_neg ^ w_dvs_neg;
            r_r_neg <= w_dvd_neg;
        end else if (w_div0) begin
            // Divide by zero: defined MIPS-style result, no iteration.
            r_lo <= '1;
            r_hi <= bus.dividend;
        end else if (w_step) begin
            r_rem <= w_rem_next;
            r_quo <= w_quo_next;
            r_cnt <= r_cnt + 1'b1;
            if (w_finish) begin
                // Negation wraps, so 0x80000000 / -1 yields 0x80000000.
                r_lo <= r_q_neg ? (~w_quo_next + 1'b1) : w_quo_next;
                r_hi <= r_r_neg ? (~w_rem_next + 1'b1) : w_rem_next;
            end
        end
    end

    // Stall while accepting a start or iterating; never in DONE so the
    // instruction can leave EX.
    assign bus.stall_req = ~rst & ~bus.flush &
                           (((r_state == IDLE) & bus.start) | (r_state == BUSY));
    assign bus.done      = ~rst & (r_state == DONE);
    assign bus.lo        = r_lo;
    assign bus.hi        = r_hi;

endmodule
`default_nettype wire

// File: tb/tb_ex_div_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_ex_div_unit
//  Purpose  : Directed bench for ex_div_unit: vector table of divides plus
//             hand-written flush, back-to-back, DONE-hold and reset cases.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ex_div_unit;

    localparam int DATA_W = 32;

    typedef struct {
        logic        sop;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] lo;
        logic [31:0] hi;
        int          stalls;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_bad = 0;
    vec_t vecs [11];

    always #5 clk = ~clk;

    ex_div_unit_if #(.DATA_W(DATA_W)) bus ();

    ex_div_unit #(.DATA_W(DATA_W), .CNT_W(6)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Present a divide to the unit (call just after a rising edge).
    task automatic issue(input logic s, input logic [31:0] a, input logic [31:0] b);
        bus.signed_op  = s;
        bus.dividend   = a;
        bus.divisor    = b;
        bus.start      = 1'b1;
        bus.ex_advance = 1'b0;
    endtask

    // Count stall cycles until the request drops, then check the result.
    // Returns at the falling edge of the first DONE cycle.
    task automatic collect(input string name, input int exp_stalls,
                           input logic [31:0] elo, input logic [31:0] ehi);
        int cnt = 0;
        bit ok  = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.stall_req) begin
                cnt++;
            end else begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s timeout: stall_req still high after 100 cycles", name);
        end
        check($sformatf("%s stall cycles", name), 32'(cnt), 32'(exp_stalls));
        check($sformatf("%s done", name), {31'b0, bus.done}, 32'd1);
        check($sformatf("%s lo", name), bus.lo, elo);
        check($sformatf("%s hi", name), bus.hi, ehi);
    endtask

    // Let the instruction leave EX and confirm done drops.
    task automatic retire(input string name);
        bus.ex_advance = 1'b1;
        bus.start      = 1'b0;
        @(posedge clk);
        #1 bus.ex_advance = 1'b0;
        @(negedge clk);
        check($sformatf("%s done after advance", name), {31'b0, bus.done}, 32'd0);
        check($sformatf("%s stall after advance", name), {31'b0, bus.stall_req}, 32'd0);
    endtask

    initial begin
        logic [31:0] prev_lo;
        logic [31:0] prev_hi;
        int          done_seen;
        int          stall_seen;

        //           sop   dividend      divisor       lo            hi            stalls
        vecs[0]  = '{1'b0, 32'd100,      32'd7,        32'h0000000E, 32'h00000002, 33};
        vecs[1]  = '{1'b1, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 32'hFFFFFFFF, 33};
        vecs[2]  = '{1'b1, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 32'h00000001, 33};
        vecs[3]  = '{1'b0, 32'd5,        32'd0,        32'hFFFFFFFF, 32'h00000005, 1};
        vecs[4]  = '{1'b1, 32'hFFFFFFF6, 32'd0,        32'hFFFFFFFF, 32'hFFFFFFF6, 1};
        vecs[5]  = '{1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h00000000, 33};
        vecs[6]  = '{1'b0, 32'hFFFFFFFF, 32'h00000010, 32'h0FFFFFFF, 32'h0000000F, 33};
        vecs[7]  = '{1'b1, 32'hFFFFFF9C, 32'hFFFFFFF9, 32'h0000000E, 32'hFFFFFFFE, 33};
        vecs[8]  = '{1'b0, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000000, 32'hFFFFFFFE, 33};
        vecs[9]  = '{1'b1, 32'h80000000, 32'd1,        32'h80000000, 32'h00000000, 33};
        vecs[10] = '{1'b0, 32'd3,        32'd9,        32'h00000000, 32'h00000003, 33};

        rst            = 1'b1;
        bus.start      = 1'b0;
        bus.signed_op  = 1'b0;
        bus.dividend   = '0;
        bus.divisor    = '0;
        bus.flush      = 1'b0;
        bus.ex_advance = 1'b0;

        // Reset state, including start held high while in reset.
        repeat (2) @(posedge clk);
        #1;
        bus.start   = 1'b1;
        bus.divisor = 32'd7;
        @(negedge clk);
        check("reset stall_req", {31'b0, bus.stall_req}, 32'd0);
        check("reset done", {31'b0, bus.done}, 32'd0);
        check("reset lo", bus.lo, 32'd0);
        check("reset hi", bus.hi, 32'd0);
        @(posedge clk);
        #1;
        rst       = 1'b0;
        bus.start = 1'b0;
        @(negedge clk);
        check("idle stall_req", {31'b0, bus.stall_req}, 32'd0);

        // Vector table.
        foreach (vecs[i]) begin
            @(posedge clk);
            #1 issue(vecs[i].sop, vecs[i].a, vecs[i].b);
            collect($sformatf("vec%0d", i), vecs[i].stalls, vecs[i].lo, vecs[i].hi);
            retire($sformatf("vec%0d", i));
        end
        prev_lo = vecs[10].lo;
        prev_hi = vecs[10].hi;

        // Flush during BUSY cycle 10.
        @(posedge clk);
        #1 issue(1'b0, 32'd100, 32'd7);
        repeat (10) @(posedge clk);
        #1;
        check("flush pre busy stall", {31'b0, bus.stall_req}, 32'd1);
        bus.flush = 1'b1;
        #1;
        check("flush stall_req", {31'b0, bus.stall_req}, 32'd0);
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        bus.start = 1'b0;
        done_seen  = 0;
        stall_seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.done) done_seen++;
            if (bus.stall_req) stall_seen++;
        end
        check("flush done cycles", 32'(done_seen), 32'd0);
        check("flush stall cycles", 32'(stall_seen), 32'd0);
        check("flush lo kept", bus.lo, prev_lo);
        check("flush hi kept", bus.hi, prev_hi);

        // Flush coinciding with start in IDLE: operation never begins.
        @(posedge clk);
        #1 issue(1'b0, 32'd100, 32'd7);
        bus.flush = 1'b1;
        #1;
        check("idle flush stall_req", {31'b0, bus.stall_req}, 32'd0);
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        bus.start = 1'b0;
        @(negedge clk);
        check("idle flush next stall", {31'b0, bus.stall_req}, 32'd0);
        check("idle flush next done", {31'b0, bus.done}, 32'd0);

        // Back-to-back with DONE held three extra cycles.
        @(posedge clk);
        #1 issue(1'b1, 32'h80000000, 32'hFFFFFFFF);
        collect("b2b first", 33, 32'h80000000, 32'h00000000);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("hold%0d done", i), {31'b0, bus.done}, 32'd1);
            check($sformatf("hold%0d stall", i), {31'b0, bus.stall_req}, 32'd0);
        end
        bus.ex_advance = 1'b1;
        @(posedge clk);
        #1 issue(1'b0, 32'hFFFFFFFF, 32'h00000010);
        collect("b2b second", 33, 32'h0FFFFFFF, 32'h0000000F);
        retire("b2b second");

        // Reset at BUSY cycle 20, then a fresh divide.
        @(posedge clk);
        #1 issue(1'b0, 32'd100, 32'd7);
        repeat (20) @(posedge clk);
        #1;
        check("midrst busy stall", {31'b0, bus.stall_req}, 32'd1);
        rst = 1'b1;
        #1;
        check("midrst stall during rst", {31'b0, bus.stall_req}, 32'd0);
        @(posedge clk);
        #1;
        rst       = 1'b0;
        bus.start = 1'b0;
        @(negedge clk);
        check("midrst stall", {31'b0, bus.stall_req}, 32'd0);
        check("midrst done", {31'b0, bus.done}, 32'd0);
        check("midrst lo", bus.lo, 32'd0);
        check("midrst hi", bus.hi, 32'd0);
        @(posedge clk);
        #1 issue(1'b0, 32'd9, 32'd3);
        collect("post rst 9/3", 33, 32'd3, 32'd0);
        retire("post rst 9/3");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Backstop against a stuck run.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
